// File: rtl/rvl_pkg.sv
// Shared types for the data-memory controller slice.
//   mem_size_t   : access size encoding on the request bus (2'b11 is illegal)
//   dmem_state_t : controller FSM states
//   MAX_DMEM_LAT : largest supported access latency (counter is 4 bits wide)
package rvl_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    localparam int MAX_DMEM_LAT = 15;

endpackage

// File: rtl/dmem_ctrl_if.sv
// MEM-stage <-> data-memory request/response bus.
//   master : MEM stage (drives proc_req/we/size/uns/addr/wdata)
//   slave  : dmem_ctrl (drives mem_rdy/valid/rdata/err)
interface dmem_ctrl_if #(
    parameter int NBITS = 32
);
    logic             proc_req;
    logic             we;
    logic [1:0]       size;
    logic             uns;
    logic [NBITS-1:0] addr;
    logic [NBITS-1:0] wdata;
    logic             mem_rdy;
    logic             valid;
    logic [NBITS-1:0] rdata;
    logic             err;

    modport master (
        output proc_req, we, size, uns, addr, wdata,
        input  mem_rdy, valid, rdata, err
    );

    modport slave (
        input  proc_req, we, size, uns, addr, wdata,
        output mem_rdy, valid, rdata, err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for a 32-bit byte-addressed word.
//   old_word : current array word at the addressed index
//   wdata    : right-justified store data
//   size     : SZ_B / SZ_H / SZ_W (2'b11 illegal)
//   uns      : zero-extend loads when 1
//   offset   : addr[1:0]
//   new_word : old_word with the store lanes merged in
//   rdata    : selected load lanes, extended to NBITS
//   err      : misaligned access or illegal size
module dmem_lane_align
    import rvl_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] old_word,
    input  logic [NBITS-1:0] wdata,
    input  logic [1:0]       size,
    input  logic             uns,
    input  logic [1:0]       offset,
    output logic [NBITS-1:0] new_word,
    output logic [NBITS-1:0] rdata,
    output logic             err
);
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign byte_sh = {offset, 3'b000};
    assign half_sh = {offset[1], 4'b0000};
    assign ld_byte = old_word[byte_sh +: 8];
    assign ld_half = old_word[half_sh +: 16];

    always_comb begin
        err = 1'b0;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = offset[0];
            SZ_W:    err = (offset != 2'b00);
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        new_word = old_word;
        case (size)
            SZ_B:    new_word[byte_sh +: 8]  = wdata[7:0];
            SZ_H:    new_word[half_sh +: 16] = wdata[15:0];
            SZ_W:    new_word                = wdata;
            default: new_word                = old_word;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (size)
            SZ_B:    rdata = uns ? {{(NBITS-8){1'b0}}, ld_byte}
                                 : {{(NBITS-8){ld_byte[7]}}, ld_byte};
            SZ_H:    rdata = uns ? {{(NBITS-16){1'b0}}, ld_half}
                                 : {{(NBITS-16){ld_half[15]}}, ld_half};
            SZ_W:    rdata = old_word;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store per handshake, LATENCY-cycle access
// into a word-organised array, single-cycle valid pulse on completion.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : dmem_ctrl_if slave (request in, mem_rdy/valid/rdata/err out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no request outstanding, mem_rdy=1
//   WAIT  | access in flight, down-counter running, mem_rdy=0
//   RESP  | valid=1 for one cycle, mem_rdy=1 (may accept next request)
module dmem_ctrl
    import rvl_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    dmem_ctrl_if.slave   bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam bit DIRECT = (LATENCY == 1);

    dmem_state_t      state;
    logic [3:0]       cnt;
    logic             mem_rdy_q;
    logic             valid_q;
    logic [NBITS-1:0] rdata_q;
    logic             err_q;

    logic             lat_we;
    logic [1:0]       lat_size;
    logic             lat_uns;
    logic [AW+1:0]    lat_addr;
    logic [NBITS-1:0] lat_wdata;

    logic [NBITS-1:0] mem [DEPTH];

    logic             accept;
    logic             enter_resp;
    logic             a_we;
    logic [1:0]       a_size;
    logic             a_uns;
    logic [AW+1:0]    a_addr;
    logic [NBITS-1:0] a_wdata;
    logic [AW-1:0]    a_idx;
    logic [NBITS-1:0] old_word;
    logic [NBITS-1:0] new_word;
    logic [NBITS-1:0] ld_data;
    logic             a_err;

    assign accept     = bus.proc_req && mem_rdy_q;
    assign enter_resp = (DIRECT && accept && (state != WAIT)) ||
                        ((state == WAIT) && (cnt == 4'd1));

    // With single-cycle latency the access happens on the accept edge itself,
    // so the array is addressed straight from the bus instead of the latch.
    assign a_we    = DIRECT ? bus.we             : lat_we;
    assign a_size  = DIRECT ? bus.size           : lat_size;
    assign a_uns   = DIRECT ? bus.uns            : lat_uns;
    assign a_addr  = DIRECT ? bus.addr[AW+1:0]   : lat_addr;
    assign a_wdata = DIRECT ? bus.wdata          : lat_wdata;
    assign a_idx   = a_addr[AW+1:2];
    assign old_word = mem[a_idx];

    dmem_lane_align #(.NBITS(NBITS)) u_align (
        .old_word (old_word),
        .wdata    (a_wdata),
        .size     (a_size),
        .uns      (a_uns),
        .offset   (a_addr[1:0]),
        .new_word (new_word),
        .rdata    (ld_data),
        .err      (a_err)
    );

    // Array is not reset; rst only blocks the write so an in-flight store is dropped.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && a_we && !a_err) begin
            mem[a_idx] <= new_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_rdy_q <= 1'b1;
            valid_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                lat_we    <= bus.we;
                lat_size  <= bus.size;
                lat_uns   <= bus.uns;
                lat_addr  <= bus.addr[AW+1:0];
                lat_wdata <= bus.wdata;
            end
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        if (DIRECT) begin
                            state     <= RESP;
                            valid_q   <= 1'b1;
                            mem_rdy_q <= 1'b1;
                        end else begin
                            state     <= WAIT;
                            cnt       <= 4'(LATENCY - 1);
                            mem_rdy_q <= 1'b0;
                        end
                    end else begin
                        state     <= IDLE;
                        mem_rdy_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        cnt       <= 4'd0;
                        valid_q   <= 1'b1;
                        mem_rdy_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_rdy_q <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                rdata_q <= (a_we || a_err) ? '0 : ld_data;
                err_q   <= a_err;
            end
        end
    end

    assign bus.mem_rdy = mem_rdy_q;
    assign bus.valid   = valid_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // index 0: LATENCY=2, 1: LATENCY=1, 2: LATENCY=4
    logic        d_req   [3];
    logic        d_we    [3];
    logic [1:0]  d_size  [3];
    logic        d_uns   [3];
    logic [31:0] d_addr  [3];
    logic [31:0] d_wdata [3];
    logic        o_rdy   [3];
    logic        o_valid [3];
    logic        o_err   [3];
    logic [31:0] o_rdata [3];

    dmem_ctrl_if #(.NBITS(32)) bus0 ();
    dmem_ctrl_if #(.NBITS(32)) bus1 ();
    dmem_ctrl_if #(.NBITS(32)) bus2 ();

    assign bus0.proc_req = d_req[0];  assign bus0.we = d_we[0];  assign bus0.size = d_size[0];
    assign bus0.uns = d_uns[0];  assign bus0.addr = d_addr[0];  assign bus0.wdata = d_wdata[0];
    assign bus1.proc_req = d_req[1];  assign bus1.we = d_we[1];  assign bus1.size = d_size[1];
    assign bus1.uns = d_uns[1];  assign bus1.addr = d_addr[1];  assign bus1.wdata = d_wdata[1];
    assign bus2.proc_req = d_req[2];  assign bus2.we = d_we[2];  assign bus2.size = d_size[2];
    assign bus2.uns = d_uns[2];  assign bus2.addr = d_addr[2];  assign bus2.wdata = d_wdata[2];

    assign o_rdy[0] = bus0.mem_rdy;  assign o_valid[0] = bus0.valid;
    assign o_err[0] = bus0.err;      assign o_rdata[0] = bus0.rdata;
    assign o_rdy[1] = bus1.mem_rdy;  assign o_valid[1] = bus1.valid;
    assign o_err[1] = bus1.err;      assign o_rdata[1] = bus1.rdata;
    assign o_rdy[2] = bus2.mem_rdy;  assign o_valid[2] = bus2.valid;
    assign o_err[2] = bus2.err;      assign o_rdata[2] = bus2.rdata;

    dmem_ctrl #(.NBITS(32), .DEPTH(1024), .LATENCY(2)) u_lat2 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_ctrl #(.NBITS(32), .DEPTH(1024), .LATENCY(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_ctrl #(.NBITS(32), .DEPTH(1024), .LATENCY(4)) u_lat4 (.clk(clk), .rst(rst), .bus(bus2));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait for its valid pulse. lat counts edges from
    // accept to valid; low counts sampled cycles with mem_rdy=0 in between.
    task automatic do_op(input int d, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er, output int lat, output int low);
        @(negedge clk);
        d_req[d] = 1'b1; d_we[d] = we; d_size[d] = size; d_uns[d] = uns;
        d_addr[d] = addr; d_wdata[d] = wdata;
        rd = 32'hx; er = 1'bx; low = 0;
        @(posedge clk); #1;
        d_req[d] = 1'b0; d_wdata[d] = 32'h0; d_addr[d] = 32'h0;
        lat = 1;
        for (int k = 0; k < 20; k++) begin
            if (o_valid[d]) begin
                rd = o_rdata[d]; er = o_err[d];
                break;
            end
            if (!o_rdy[d]) low++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [19];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, low, pulses;
        logic [31:0] b2b_exp [4];

        for (int i = 0; i < 3; i++) begin
            d_req[i] = 0; d_we[i] = 0; d_size[i] = 0; d_uns[i] = 0; d_addr[i] = 0; d_wdata[i] = 0;
        end

        //         we    size   uns   addr          wdata          exp_rdata      err
        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h13,       32'h00000080, 32'h0,        1'b0};
        vt[3]  = '{1'b0, 2'b00, 1'b0, 32'h13,       32'h0,        32'hFFFFFF80, 1'b0};
        vt[4]  = '{1'b0, 2'b00, 1'b1, 32'h13,       32'h0,        32'h00000080, 1'b0};
        vt[5]  = '{1'b0, 2'b10, 1'b1, 32'h10,       32'h0,        32'h80ADBEEF, 1'b0};
        vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h12,       32'h0,        32'hFFFF80AD, 1'b0};
        vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h12,       32'h0,        32'h000080AD, 1'b0};
        vt[8]  = '{1'b1, 2'b01, 1'b0, 32'h11,       32'h00001234, 32'h0,        1'b1};
        vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'h80ADBEEF, 1'b0};
        vt[10] = '{1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        32'h0,        1'b1};
        vt[11] = '{1'b0, 2'b10, 1'b0, 32'h12,       32'h0,        32'h0,        1'b1};
        vt[12] = '{1'b1, 2'b01, 1'b0, 32'h12,       32'hFFFFCAFE, 32'h0,        1'b0};
        vt[13] = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hCAFEBEEF, 1'b0};
        vt[14] = '{1'b0, 2'b01, 1'b0, 32'h10,       32'h0,        32'hFFFFBEEF, 1'b0};
        vt[15] = '{1'b1, 2'b00, 1'b0, 32'h10,       32'hAABBCC11, 32'h0,        1'b0};
        vt[16] = '{1'b0, 2'b10, 1'b0, 32'hFFFF1010, 32'h0,        32'hCAFEBE11, 1'b0};
        vt[17] = '{1'b1, 2'b11, 1'b0, 32'h10,       32'h99999999, 32'h0,        1'b1};
        vt[18] = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hCAFEBE11, 1'b0};

        // Reset, with a request on the LATENCY=4 instance that must be ignored.
        d_req[2] = 1'b1; d_we[2] = 1'b1; d_size[2] = 2'b10; d_addr[2] = 32'h24; d_wdata[2] = 32'hBAD0BAD0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        d_req[2] = 1'b0;
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("idle_rdy c%0d", c),   {31'b0, o_rdy[0]},   32'd1);
            chk($sformatf("idle_valid c%0d", c), {31'b0, o_valid[0]}, 32'd0);
            chk($sformatf("idle_rdata c%0d", c), o_rdata[0],          32'h0);
            if (o_valid[2]) pulses++;
        end
        chk("req_in_reset_ignored", pulses, 0);

        // Table vectors on the LATENCY=2 instance, issued back-to-back.
        for (int i = 0; i < 19; i++) begin
            do_op(0, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er, lat, low);
            chk($sformatf("v%0d_lat", i),   lat, 2);
            chk($sformatf("v%0d_rdylow", i), low, 1);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("v%0d_err", i),   {31'b0, er}, {31'b0, vt[i].exp_err});
        end

        // rdata/err hold after the valid pulse.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_valid c%0d", c), {31'b0, o_valid[0]}, 32'd0);
            chk($sformatf("hold_rdata c%0d", c), o_rdata[0], 32'hCAFEBE11);
        end

        // LATENCY=1: preload four words, then stream four loads with proc_req held.
        b2b_exp[0] = 32'h0A0B0C0D; b2b_exp[1] = 32'h11223344;
        b2b_exp[2] = 32'h8899AABB; b2b_exp[3] = 32'hF00DFACE;
        for (int i = 0; i < 4; i++) begin
            do_op(1, 1'b1, 2'b10, 1'b0, 32'(i * 4), b2b_exp[i], rd, er, lat, low);
            chk($sformatf("l1_store%0d_lat", i), lat, 1);
        end
        @(negedge clk);
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_size[1] = 2'b10; d_uns[1] = 1'b0; d_addr[1] = 32'h0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_rdy", i), {31'b0, o_rdy[1]}, 32'd1);
            chk($sformatf("b2b%0d_rdata", i), o_rdata[1], b2b_exp[i]);
            if (o_valid[1]) pulses++;
            if (i == 3) d_req[1] = 1'b0;
            else d_addr[1] = 32'((i + 1) * 4);
        end
        chk("b2b_pulses", pulses, 4);
        @(posedge clk); #1;
        chk("b2b_after_valid", {31'b0, o_valid[1]}, 32'd0);

        // LATENCY=4: reset two cycles after accepting a store.
        do_op(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11112222, rd, er, lat, low);
        chk("l4_store_lat", lat, 4);
        chk("l4_store_rdylow", low, 3);
        do_op(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, low);
        chk("l4_load_rdata", rd, 32'h11112222);
        @(negedge clk);
        d_req[2] = 1'b1; d_we[2] = 1'b1; d_size[2] = 2'b10; d_addr[2] = 32'h20; d_wdata[2] = 32'h5555AAAA;
        @(posedge clk); #1;
        d_req[2] = 1'b0;
        chk("midop_rdy_low", {31'b0, o_rdy[2]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midop_rst_rdy",   {31'b0, o_rdy[2]},   32'd1);
        chk("midop_rst_valid", {31'b0, o_valid[2]}, 32'd0);
        chk("midop_rst_rdata", o_rdata[2], 32'h0);
        chk("midop_rst_err",   {31'b0, o_err[2]},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (o_valid[2]) pulses++;
        end
        chk("midop_no_valid", pulses, 0);
        do_op(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, low);
        chk("midop_load_lat", lat, 4);
        chk("midop_load_rdata", rd, 32'h11112222);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
